bank_isu_fifo_q: RTL and testbench
==================================

// Module: bank_isu_fifo_q
// PURPOSE
//  Parametrised in-order issue queue for one cache bank. Sits between the bank request
//  arbiter (enqueue) and the bank data pipeline (issue). Supersedes the enqueue-only queue
//  with the following additions:
//   - dequeue/issue handshake and full/empty/occupancy status;
//   - per-channel occupancy counters;
//   - synchronous flush;
//   - field widths set by parameter.
// PARAMETERS
//  PTR_W    6  log2 of queue depth; DEPTH = 1<<PTR_W
//  CH_N     4  number of requesting channels; CH_W = $clog2(CH_N), minimum 1
//  ROB_W    3  ROB id width
//  OPC_W    2  opcode width; all bits are stored
//  SWO_W    7  set/way/offset width
//  WBUF_W   8  write-buffer id width; all bits are stored
// PORTS
//  clk_i           in   1             clock, rising edge
//  rst_i           in   1             reset, asynchronous, active-high
//  req_valid_i     in   1             enqueue request
//  req_allowIn_o   out  1             queue can accept; equals !full
//  req_rob_id_i    in   ROB_W         ROB id
//  req_ch_id_i     in   CH_W          source channel
//  req_opcode_i    in   OPC_W         opcode
//  req_swo_i       in   SWO_W         set/way/offset
//  req_wbuf_id_i   in   WBUF_W        write-buffer id
//  req_cl_state_i  in   4             {offset1_state[1:0], offset0_state[1:0]}
//  iss_valid_o     out  1             head entry valid; equals !empty
//  iss_ready_i     in   1             downstream accepts head
//  iss_rob_id_o / iss_ch_id_o / iss_opcode_o / iss_swo_o / iss_wbuf_id_o / iss_cl_state_o
//                  out  field widths  head entry fields; registered-array read at rd_ptr
//  flush_i         in   1             drop all entries
//  count_o         out  PTR_W+1       occupancy, 0..DEPTH
//  ch_count_o      out  CH_N*(PTR_W+1) per-channel occupancy; channel c at slice c
// BEHAVIOUR
//  - Reset: wr_ptr=0, rd_ptr=0, count=0, all ch_count=0.
//    Resulting outputs: req_allowIn_o=1, iss_valid_o=0, count_o=0.
//  - Payload array has no reset. iss_* fields are don't-care while iss_valid_o=0.
//  - Enqueue fires (enq) when req_valid_i & req_allowIn_o. The entry is written at wr_ptr
//    on that edge; wr_ptr increments mod DEPTH.
//  - Issue fires (deq) when iss_valid_o & iss_ready_i. rd_ptr increments mod DEPTH.
//    Latency: an entry enqueued at edge N is visible on iss_* after edge N (0 bubble).
//    No combinational path from req_* to iss_*.
//  - allowIn is !full only: no same-cycle enqueue when full, even if deq fires.
//    Keeps iss_ready_i -> req_allowIn_o free of combinational paths.
//  - Simultaneous enq & deq (queue not full, not empty): count is unchanged; both pointers advance.
//  - count arithmetic is full PTR_W+1 bits: count += enq - deq. Never exceeds DEPTH; never below 0.
//  - ch_count[c] += (enq && req_ch_id_i==c) - (deq && head ch==c).
//    Enqueue and issue on the same channel in one cycle leaves ch_count[c] unchanged.
//  - Pointer wrap: DEPTH-1 -> 0. Full is count==DEPTH; pointers are equal both when full
//    and when empty, and count distinguishes the two.
//  - flush_i has priority over enq and deq in the same cycle.
//    On the next edge: pointers=0, count=0, all ch_count=0.
//    req_allowIn_o stays combinational (!full), but any enq or deq in the flush cycle is discarded.
//  - Reset mid-operation: everything returns to its reset state immediately (async).
//    Stored payload is stale and unobservable.
//  - req_ch_id_i >= CH_N: the entry is still queued, but no ch_count changes.
//    The assertion in the bench must fire.
// STRUCTURE
//  - bank_pkg holds: opcode localparams (OPC_READ, OPC_WRITE, OPC_EVICT, OPC_FILL),
//    default field widths, and the cl_state 2-bit encoding (INV/CLEAN/DIRTY/PEND).
//  - Sub-module bank_isu_fifo_ctrl (params PTR_W):
//    - inputs enq, deq, flush;
//    - outputs wr_ptr, rd_ptr, count, full, empty.
//  - The top holds the payload arrays, one per field, written only on enq.
//  - The top also holds the CH_N per-channel counters.
// TESTING
//  1. Reset, idle: count_o=0, iss_valid_o=0, req_allowIn_o=1.
//  2. Fill: 64 enqueues (rob_id=i%8, ch=i%4), PTR_W=6, iss_ready_i=0 -> count_o=64,
//     req_allowIn_o=0, ch_count each 16. 65th request is not accepted and count stays 64.
//  3. Drain: from case 2, iss_ready_i=1 for 64 cycles -> 64 issues in enqueue order, rob ids 0..7 repeating.
//     Then iss_valid_o=0 and req_allowIn_o=1.
//  4. Simultaneous: count=5, enq ch1 and deq of a ch1 head in the same cycle -> count 5, ch_count[1] unchanged.
//     wr_ptr and rd_ptr both wrap cleanly across 63->0 over 70 such cycles.
//  5. Flush with enq+deq asserted: count=10 -> next cycle count=0, iss_valid_o=0, all ch_count=0.
//  6. Async reset asserted mid-burst between edges -> outputs at reset values before the next edge.
//     The first post-reset enqueue appears on iss_* one edge after it is accepted.

Source files
------------

// File: rtl/bank_pkg.sv
// Shared definitions for the cache-bank issue path: default field widths,
// opcode values and the 2-bit cache-line state encoding.
package bank_pkg;

    localparam int PTR_W_DEF  = 6;
    localparam int CH_N_DEF   = 4;
    localparam int ROB_W_DEF  = 3;
    localparam int OPC_W_DEF  = 2;
    localparam int SWO_W_DEF  = 7;
    localparam int WBUF_W_DEF = 8;
    localparam int CL_W       = 4;  // {offset1_state, offset0_state}

    localparam logic [1:0] OPC_READ  = 2'd0;
    localparam logic [1:0] OPC_WRITE = 2'd1;
    localparam logic [1:0] OPC_EVICT = 2'd2;
    localparam logic [1:0] OPC_FILL  = 2'd3;

    typedef enum logic [1:0] {
        CL_INV   = 2'd0,
        CL_CLEAN = 2'd1,
        CL_DIRTY = 2'd2,
        CL_PEND  = 2'd3
    } cl_state_e;

    // Channel-id width: a single channel still gets a 1-bit id field.
    function automatic int ch_w_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bank_isu_fifo_ctrl.sv
// Pointer/occupancy control for the bank issue queue. The count carries one
// extra bit so that full (count==DEPTH) and empty (count==0) are distinct
// even though the pointers are equal in both cases.
module bank_isu_fifo_ctrl #(
    parameter int PTR_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enq,
    input  logic             deq,
    input  logic             flush,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] DEPTH_C = {1'b1, {PTR_W{1'b0}}};

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    // Pointers wrap naturally at DEPTH; flush wins over any enq/deq in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (enq) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (deq) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            count_r <= count_r + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
        end
    end

    assign wr_ptr = wr_ptr_r;
    assign rd_ptr = rd_ptr_r;
    assign count  = count_r;
    assign full   = (count_r == DEPTH_C);
    assign empty  = (count_r == {(PTR_W+1){1'b0}});

endmodule

// File: rtl/bank_isu_fifo_q.sv
// In-order issue queue for one cache bank: enqueue from the request arbiter,
// issue to the bank data pipeline, with total and per-channel occupancy and a
// synchronous flush. allowIn depends only on the registered count, so there is
// no combinational path from iss_ready_i to req_allowIn_o.
module bank_isu_fifo_q
    import bank_pkg::*;
#(
    parameter int   PTR_W  = PTR_W_DEF,
    parameter int   CH_N   = CH_N_DEF,
    parameter int   ROB_W  = ROB_W_DEF,
    parameter int   OPC_W  = OPC_W_DEF,
    parameter int   SWO_W  = SWO_W_DEF,
    parameter int   WBUF_W = WBUF_W_DEF,
    localparam int  CH_W   = ch_w_f(CH_N)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_allowIn_o,
    input  logic [ROB_W-1:0]          req_rob_id_i,
    input  logic [CH_W-1:0]           req_ch_id_i,
    input  logic [OPC_W-1:0]          req_opcode_i,
    input  logic [SWO_W-1:0]          req_swo_i,
    input  logic [WBUF_W-1:0]         req_wbuf_id_i,
    input  logic [CL_W-1:0]           req_cl_state_i,
    output logic                      iss_valid_o,
    input  logic                      iss_ready_i,
    output logic [ROB_W-1:0]          iss_rob_id_o,
    output logic [CH_W-1:0]           iss_ch_id_o,
    output logic [OPC_W-1:0]          iss_opcode_o,
    output logic [SWO_W-1:0]          iss_swo_o,
    output logic [WBUF_W-1:0]         iss_wbuf_id_o,
    output logic [CL_W-1:0]           iss_cl_state_o,
    input  logic                      flush_i,
    output logic [PTR_W:0]            count_o,
    output logic [CH_N*(PTR_W+1)-1:0] ch_count_o
);

    localparam int DEPTH = 1 << PTR_W;
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_s;
    logic [PTR_W-1:0] rd_ptr_s;
    logic             full_s;
    logic             empty_s;
    logic             enq_s;
    logic             deq_s;
    logic [CH_N-1:0]  ch_inc_s;
    logic [CH_N-1:0]  ch_dec_s;

    logic [ROB_W-1:0]  rob_mem_r  [DEPTH];
    logic [CH_W-1:0]   ch_mem_r   [DEPTH];
    logic [OPC_W-1:0]  opc_mem_r  [DEPTH];
    logic [SWO_W-1:0]  swo_mem_r  [DEPTH];
    logic [WBUF_W-1:0] wbuf_mem_r [DEPTH];
    logic [CL_W-1:0]   cl_mem_r   [DEPTH];

    logic [CNT_W-1:0]  ch_cnt_r   [CH_N];

    assign req_allowIn_o = ~full_s;
    assign iss_valid_o   = ~empty_s;
    // Handshakes in a flush cycle are discarded.
    assign enq_s = req_valid_i & ~full_s & ~flush_i;
    assign deq_s = iss_ready_i & ~empty_s & ~flush_i;

    bank_isu_fifo_ctrl #(
        .PTR_W (PTR_W)
    ) u_ctrl (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .enq    (enq_s),
        .deq    (deq_s),
        .flush  (flush_i),
        .wr_ptr (wr_ptr_s),
        .rd_ptr (rd_ptr_s),
        .count  (count_o),
        .full   (full_s),
        .empty  (empty_s)
    );

    // Payload capture on accepted enqueue; unreset because only valid entries are ever read.
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            rob_mem_r[wr_ptr_s]  <= req_rob_id_i;
            ch_mem_r[wr_ptr_s]   <= req_ch_id_i;
            opc_mem_r[wr_ptr_s]  <= req_opcode_i;
            swo_mem_r[wr_ptr_s]  <= req_swo_i;
            wbuf_mem_r[wr_ptr_s] <= req_wbuf_id_i;
            cl_mem_r[wr_ptr_s]   <= req_cl_state_i;
        end
    end

    assign iss_rob_id_o   = rob_mem_r[rd_ptr_s];
    assign iss_ch_id_o    = ch_mem_r[rd_ptr_s];
    assign iss_opcode_o   = opc_mem_r[rd_ptr_s];
    assign iss_swo_o      = swo_mem_r[rd_ptr_s];
    assign iss_wbuf_id_o  = wbuf_mem_r[rd_ptr_s];
    assign iss_cl_state_o = cl_mem_r[rd_ptr_s];

    // Per-channel up/down decode; out-of-range channel ids match no counter.
    always_comb begin
        ch_inc_s = {CH_N{1'b0}};
        ch_dec_s = {CH_N{1'b0}};
        for (int c = 0; c < CH_N; c++) begin
            ch_inc_s[c] = enq_s & (req_ch_id_i == CH_W'(c));
            ch_dec_s[c] = deq_s & (iss_ch_id_o == CH_W'(c));
        end
    end

    // Per-channel occupancy counters; same-channel enq+deq cancels out.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < CH_N; c++) begin
                ch_cnt_r[c] <= {CNT_W{1'b0}};
            end
        end else if (flush_i) begin
            for (int c = 0; c < CH_N; c++) begin
                ch_cnt_r[c] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int c = 0; c < CH_N; c++) begin
                ch_cnt_r[c] <= ch_cnt_r[c] + CNT_W'(ch_inc_s[c]) - CNT_W'(ch_dec_s[c]);
            end
        end
    end

    for (genvar g = 0; g < CH_N; g++) begin : g_ch_out
        assign ch_count_o[g*CNT_W +: CNT_W] = ch_cnt_r[g];
    end

endmodule

// File: tb/tb_bank_isu_fifo_q.sv
// Directed bench for bank_isu_fifo_q. A queue-based reference model tracks
// the architectural contents; a negedge process compares every output to it,
// and the directed sequence adds hand-computed literal expectations.
module tb_bank_isu_fifo_q;

    localparam int PTR_W  = 6;
    localparam int CH_N   = 4;
    localparam int CH_W   = 2;
    localparam int ROB_W  = 3;
    localparam int OPC_W  = 2;
    localparam int SWO_W  = 7;
    localparam int WBUF_W = 8;
    localparam int CL_W   = 4;
    localparam int DEPTH  = 64;
    localparam int CW     = PTR_W + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid;
    logic                 req_allowIn;
    logic [ROB_W-1:0]     req_rob_id;
    logic [CH_W-1:0]      req_ch_id;
    logic [OPC_W-1:0]     req_opcode;
    logic [SWO_W-1:0]     req_swo;
    logic [WBUF_W-1:0]    req_wbuf_id;
    logic [CL_W-1:0]      req_cl_state;
    logic                 iss_valid;
    logic                 iss_ready;
    logic [ROB_W-1:0]     iss_rob_id;
    logic [CH_W-1:0]      iss_ch_id;
    logic [OPC_W-1:0]     iss_opcode;
    logic [SWO_W-1:0]     iss_swo;
    logic [WBUF_W-1:0]    iss_wbuf_id;
    logic [CL_W-1:0]      iss_cl_state;
    logic                 flush;
    logic [PTR_W:0]       count;
    logic [CH_N*CW-1:0]   ch_count;

    bank_isu_fifo_q dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_allowIn_o  (req_allowIn),
        .req_rob_id_i   (req_rob_id),
        .req_ch_id_i    (req_ch_id),
        .req_opcode_i   (req_opcode),
        .req_swo_i      (req_swo),
        .req_wbuf_id_i  (req_wbuf_id),
        .req_cl_state_i (req_cl_state),
        .iss_valid_o    (iss_valid),
        .iss_ready_i    (iss_ready),
        .iss_rob_id_o   (iss_rob_id),
        .iss_ch_id_o    (iss_ch_id),
        .iss_opcode_o   (iss_opcode),
        .iss_swo_o      (iss_swo),
        .iss_wbuf_id_o  (iss_wbuf_id),
        .iss_cl_state_o (iss_cl_state),
        .flush_i        (flush),
        .count_o        (count),
        .ch_count_o     (ch_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ROB_W-1:0]  rob;
        logic [CH_W-1:0]   ch;
        logic [OPC_W-1:0]  opc;
        logic [SWO_W-1:0]  swo;
        logic [WBUF_W-1:0] wbuf;
        logic [CL_W-1:0]   cl;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   m_enq;
    bit   m_deq;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int model_ch_count(input int c);
        int n = 0;
        foreach (q[k]) if (int'(q[k].ch) == c) n++;
        return n;
    endfunction

    // Reference model: a FIFO of accepted entries, cleared by reset or flush.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            m_enq = req_valid && (q.size() < DEPTH);
            m_deq = iss_ready && (q.size() > 0);
            if (m_deq) void'(q.pop_front());
            if (m_enq) q.push_back({req_rob_id, req_ch_id, req_opcode, req_swo, req_wbuf_id, req_cl_state});
        end
    end

    // Every channel id accepted must name a real channel.
    always @(posedge clk) begin
        if (!rst && req_valid && req_allowIn)
            assert (int'(req_ch_id) < CH_N) else $error("channel id %0d out of range", req_ch_id);
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("m_count", count, q.size());
        chk("m_allowIn", req_allowIn, (q.size() != DEPTH));
        chk("m_iss_valid", iss_valid, (q.size() != 0));
        for (int c = 0; c < CH_N; c++)
            chk($sformatf("m_ch_count%0d", c), ch_count[c*CW +: CW], model_ch_count(c));
        if (q.size() != 0) begin
            chk("m_rob", iss_rob_id, q[0].rob);
            chk("m_ch", iss_ch_id, q[0].ch);
            chk("m_opc", iss_opcode, q[0].opc);
            chk("m_swo", iss_swo, q[0].swo);
            chk("m_wbuf", iss_wbuf_id, q[0].wbuf);
            chk("m_cl", iss_cl_state, q[0].cl);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input int rob, input int ch, input int i);
        req_valid    = v;
        req_rob_id   = ROB_W'(rob);
        req_ch_id    = CH_W'(ch);
        req_opcode   = OPC_W'(i % 4);
        req_swo      = SWO_W'((i * 3) % 128);
        req_wbuf_id  = WBUF_W'((i * 5 + 1) % 256);
        req_cl_state = CL_W'(i % 16);
    endtask

    task automatic chk_ch_all(input string name, input int exp);
        for (int c = 0; c < CH_N; c++)
            chk($sformatf("%s%0d", name, c), ch_count[c*CW +: CW], exp);
    endtask

    initial begin
        rst       = 1'b1;
        iss_ready = 1'b0;
        flush     = 1'b0;
        drv(1'b0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1. reset / idle
        chk("rst_count", count, 0);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_allowIn", req_allowIn, 1);
        chk_ch_all("rst_ch", 0);

        // 2. fill to DEPTH, then a rejected 65th request
        for (int i = 0; i < 64; i++) begin
            drv(1'b1, i % 8, i % 4, i);
            tick();
        end
        chk("fill_count", count, 64);
        chk("fill_allowIn", req_allowIn, 0);
        chk_ch_all("fill_ch", 16);
        drv(1'b1, 7, 3, 99);
        tick();
        drv(1'b0, 0, 0, 0);
        chk("fill65_count", count, 64);
        chk("fill65_allowIn", req_allowIn, 0);

        // 3. drain in enqueue order
        iss_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            chk("drain_valid", iss_valid, 1);
            chk("drain_rob", iss_rob_id, i % 8);
            chk("drain_ch", iss_ch_id, i % 4);
            tick();
        end
        iss_ready = 1'b0;
        chk("drain_empty", iss_valid, 0);
        chk("drain_allowIn", req_allowIn, 1);
        chk("drain_count", count, 0);

        // 4. simultaneous enq/deq on channel 1, 70 cycles across the pointer wrap
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, i, 1, i);
            tick();
        end
        chk("sim_pre_count", count, 5);
        iss_ready = 1'b1;
        for (int i = 0; i < 70; i++) begin
            drv(1'b1, (i + 5) % 8, 1, i + 5);
            tick();
            chk("sim_count", count, 5);
            chk("sim_ch1", ch_count[1*CW +: CW], 5);
        end
        iss_ready = 1'b0;

        // 5. flush with enq and deq asserted
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, i, i % 4, i + 80);
            tick();
        end
        chk("flush_pre_count", count, 10);
        drv(1'b1, 3, 2, 90);
        iss_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        iss_ready = 1'b0;
        drv(1'b0, 0, 0, 0);
        chk("flush_count", count, 0);
        chk("flush_iss_valid", iss_valid, 0);
        chk("flush_allowIn", req_allowIn, 1);
        chk_ch_all("flush_ch", 0);

        // 6. asynchronous reset between edges during a burst
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, i + 2, i, i + 100);
            tick();
        end
        chk("burst_count", count, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_iss_valid", iss_valid, 0);
        chk("arst_allowIn", req_allowIn, 1);
        chk_ch_all("arst_ch", 0);
        drv(1'b0, 0, 0, 0);
        #2;
        rst = 1'b0;
        drv(1'b1, 5, 2, 7);
        chk("post_pre_valid", iss_valid, 0);
        tick();
        drv(1'b0, 0, 0, 0);
        chk("post_valid", iss_valid, 1);
        chk("post_rob", iss_rob_id, 5);
        chk("post_ch", iss_ch_id, 2);
        chk("post_count", count, 1);
        chk("post_ch2", ch_count[2*CW +: CW], 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
